// File: rtl/stall_ctrl.sv
// Pipeline hazard controller: per-stage stall vector, deferred branch
// redirect across data-memory stalls, and saturating event counters.
module stall_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall_req,
    input  logic        id_stall_req,
    input  logic        mem_stall_req,
    input  logic        ex_jump_req,
    input  logic [31:0] ex_jump_addr,
    output logic [4:0]  stall_signal,
    output logic        jump_flag,
    output logic [31:0] jump_addr,
    output logic [31:0] stall_cycles,
    output logic [15:0] jump_count
);

    typedef enum logic {
        RUN,
        HOLD_JUMP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pending_addr;
    logic [31:0] pending_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= RUN;
            pending_addr <= 32'd0;
        end else begin
            state        <= state_nxt;
            pending_addr <= pending_nxt;
        end
    end

    // A redirect raised during a memory stall is parked until MEM frees up.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending_addr;
        jump_flag   = 1'b0;
        jump_addr   = 32'd0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (ex_jump_req) begin
                        if (mem_stall_req) begin
                            pending_nxt = ex_jump_addr;
                            state_nxt   = HOLD_JUMP;
                        end else begin
                            jump_flag = 1'b1;
                            jump_addr = ex_jump_addr;
                        end
                    end
                end
                HOLD_JUMP: begin
                    if (!mem_stall_req) begin
                        jump_flag = 1'b1;
                        jump_addr = pending_addr;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // Wrong-path id/if requests are dropped while a redirect is taken.
    always_comb begin
        stall_signal = 5'b00000;
        if (rst) begin
            if (mem_stall_req)
                stall_signal = 5'b11111;
            else if (jump_flag)
                stall_signal = 5'b00000;
            else if (id_stall_req)
                stall_signal = 5'b00111;
            else if (if_stall_req)
                stall_signal = 5'b00011;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles <= 32'd0;
            jump_count   <= 16'd0;
        end else begin
            if (stall_signal != 5'b00000 && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (jump_flag && jump_count != 16'hFFFF)
                jump_count <= jump_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_stall_ctrl.sv
// Scoreboard bench for stall_ctrl: directed per-cycle vectors queue their
// expected response; a negedge monitor pops and compares.
module tb_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_stall_req;
    logic        id_stall_req;
    logic        mem_stall_req;
    logic        ex_jump_req;
    logic [31:0] ex_jump_addr;
    logic [4:0]  stall_signal;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic [31:0] stall_cycles;
    logic [15:0] jump_count;

    stall_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .if_stall_req  (if_stall_req),
        .id_stall_req  (id_stall_req),
        .mem_stall_req (mem_stall_req),
        .ex_jump_req   (ex_jump_req),
        .ex_jump_addr  (ex_jump_addr),
        .stall_signal  (stall_signal),
        .jump_flag     (jump_flag),
        .jump_addr     (jump_addr),
        .stall_cycles  (stall_cycles),
        .jump_count    (jump_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [4:0]  st;
        logic        jf;
        logic [31:0] ja;
        bit          chk;
        logic [31:0] sc;
        logic [15:0] jc;
    } exp_t;

    exp_t q[$];
    int   applied = 0;
    int   miscompares = 0;
    int   vec_id = 0;

    // Counter expectations are the values registered before this cycle's edge.
    task automatic step(input logic r, input logic fi, input logic di,
                        input logic mi, input logic jr, input logic [31:0] ja,
                        input logic [4:0] e_st, input logic e_jf,
                        input logic [31:0] e_ja, input bit chk,
                        input logic [31:0] e_sc, input logic [15:0] e_jc);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        if_stall_req  = fi;
        id_stall_req  = di;
        mem_stall_req = mi;
        ex_jump_req   = jr;
        ex_jump_addr  = ja;
        vec_id++;
        e.id  = vec_id;
        e.st  = e_st;
        e.jf  = e_jf;
        e.ja  = e_ja;
        e.chk = chk;
        e.sc  = e_sc;
        e.jc  = e_jc;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            applied++;
            if (stall_signal !== e.st) begin
                miscompares++;
                $display("FAIL v%0d stall_signal got %b want %b",
                         e.id, stall_signal, e.st);
            end
            if (jump_flag !== e.jf) begin
                miscompares++;
                $display("FAIL v%0d jump_flag got %b want %b",
                         e.id, jump_flag, e.jf);
            end
            if (jump_addr !== e.ja) begin
                miscompares++;
                $display("FAIL v%0d jump_addr got %h want %h",
                         e.id, jump_addr, e.ja);
            end
            if (e.chk && stall_cycles !== e.sc) begin
                miscompares++;
                $display("FAIL v%0d stall_cycles got %h want %h",
                         e.id, stall_cycles, e.sc);
            end
            if (e.chk && jump_count !== e.jc) begin
                miscompares++;
                $display("FAIL v%0d jump_count got %h want %h",
                         e.id, jump_count, e.jc);
            end
        end
    end

    localparam logic [31:0] Z = 32'd0;

    initial begin
        rst = 1'b0; if_stall_req = 1'b0; id_stall_req = 1'b0;
        mem_stall_req = 1'b0; ex_jump_req = 1'b0; ex_jump_addr = Z;

        // reset forces outputs low even with requests active
        step(0, 1, 1, 1, 1, 32'h0000_9999, 5'b00000, 0, Z, 0, Z, 16'd0);
        step(0, 1, 1, 0, 1, 32'h0000_8888, 5'b00000, 0, Z, 1, Z, 16'd0);
        step(1, 0, 0, 0, 0, Z, 5'b00000, 0, Z, 1, 32'd0, 16'd0);
        // load-use stall for two cycles
        step(1, 0, 1, 0, 0, Z, 5'b00111, 0, Z, 1, 32'd0, 16'd0);
        step(1, 0, 1, 0, 0, Z, 5'b00111, 0, Z, 1, 32'd1, 16'd0);
        step(1, 0, 0, 0, 0, Z, 5'b00000, 0, Z, 1, 32'd2, 16'd0);
        // jump overrides id stall
        step(1, 0, 1, 0, 1, 32'h0000_1000, 5'b00000, 1, 32'h0000_1000,
             1, 32'd2, 16'd0);
        step(1, 0, 0, 0, 0, Z, 5'b00000, 0, Z, 1, 32'd2, 16'd1);
        // jump deferred across a 3-cycle memory stall
        step(1, 0, 0, 1, 1, 32'h0000_2040, 5'b11111, 0, Z, 1, 32'd2, 16'd1);
        step(1, 0, 0, 1, 1, 32'h0000_DEAD, 5'b11111, 0, Z, 1, 32'd3, 16'd1);
        step(1, 0, 1, 1, 0, Z, 5'b11111, 0, Z, 1, 32'd4, 16'd1);
        step(1, 0, 1, 0, 1, 32'h0000_3000, 5'b00000, 1, 32'h0000_2040,
             1, 32'd5, 16'd1);
        step(1, 0, 0, 0, 0, Z, 5'b00000, 0, Z, 1, 32'd5, 16'd2);
        // mem over if, then if alone
        step(1, 1, 0, 1, 0, Z, 5'b11111, 0, Z, 1, 32'd5, 16'd2);
        step(1, 1, 0, 0, 0, Z, 5'b00011, 0, Z, 1, 32'd6, 16'd2);
        step(1, 0, 0, 0, 0, Z, 5'b00000, 0, Z, 1, 32'd7, 16'd2);
        // reset while holding a deferred jump discards it
        step(1, 0, 0, 1, 1, 32'h0000_4000, 5'b11111, 0, Z, 1, 32'd7, 16'd2);
        step(0, 0, 0, 0, 0, Z, 5'b00000, 0, Z, 1, 32'd8, 16'd2);
        step(1, 0, 0, 0, 0, Z, 5'b00000, 0, Z, 1, 32'd0, 16'd0);
        step(1, 0, 0, 0, 0, Z, 5'b00000, 0, Z, 1, 32'd0, 16'd0);
        // plain jump after reset
        step(1, 0, 0, 0, 1, 32'h0000_5000, 5'b00000, 1, 32'h0000_5000,
             1, 32'd0, 16'd0);
        step(1, 0, 0, 0, 0, Z, 5'b00000, 0, Z, 1, 32'd0, 16'd1);

        // stall counter saturation from a preloaded value
        @(posedge clk);
        #2;
        force dut.stall_cycles = 32'hFFFF_FFFE;
        force dut.jump_count   = 16'hFFFE;
        #1;
        release dut.stall_cycles;
        release dut.jump_count;
        step(1, 1, 0, 0, 0, Z, 5'b00011, 0, Z, 1, 32'hFFFF_FFFE, 16'hFFFE);
        step(1, 1, 0, 0, 0, Z, 5'b00011, 0, Z, 1, 32'hFFFF_FFFF, 16'hFFFE);
        step(1, 1, 0, 0, 0, Z, 5'b00011, 0, Z, 1, 32'hFFFF_FFFF, 16'hFFFE);
        step(1, 0, 0, 0, 0, Z, 5'b00000, 0, Z, 1, 32'hFFFF_FFFF, 16'hFFFE);
        // jump counter saturation
        step(1, 0, 0, 0, 1, 32'h0000_6000, 5'b00000, 1, 32'h0000_6000,
             1, 32'hFFFF_FFFF, 16'hFFFE);
        step(1, 0, 0, 0, 1, 32'h0000_7000, 5'b00000, 1, 32'h0000_7000,
             1, 32'hFFFF_FFFF, 16'hFFFF);
        step(1, 0, 0, 0, 0, Z, 5'b00000, 0, Z, 1, 32'hFFFF_FFFF, 16'hFFFF);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain queue left %0d want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
